// File: rtl/input_byte_controller.sv
// Switch-bank / enter-button sequencer for the core's byte-read instruction.
// Optional sticky overrun detection is built only when INPUT_OVERRUN_EN is defined.
module input_byte_controller #(
    parameter int SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in,
    input  logic       strobe,
    input  logic       req,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       ack,
    output logic       waiting,
    output logic       overrun
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE_CYCLES);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ARMED   = 3'd1;
    localparam logic [2:0] ST_SETTLE  = 3'd2;
    localparam logic [2:0] ST_PRESENT = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;

    logic [7:0]       in_meta_q, in_meta_d, in_s_q, in_s_d;
    logic             strobe_meta_q, strobe_meta_d, strobe_s_q, strobe_s_d;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       shadow_q, shadow_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             data_valid_q, data_valid_d;
    logic             waiting_q, waiting_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c >= SETTLE_C) ? SETTLE_C : c + CNT_W'(1);
    endfunction

    always_comb begin
        in_meta_d     = in;
        in_s_d        = in_meta_q;
        strobe_meta_d = strobe;
        strobe_s_d    = strobe_meta_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d        = '0;
                data_valid_d = 1'b0;
                if (req) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!req) begin
                    state_d = ST_IDLE;
                end else if (strobe_s_q) begin
                    state_d  = ST_SETTLE;
                    cnt_d    = CNT_W'(1);
                    shadow_d = in_s_q;
                end
            end
            ST_SETTLE: begin
                // Bounce is checked before the terminal count so a byte that
                // changes on the last settle cycle is never captured.
                if (!req) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (!strobe_s_q || (in_s_q != shadow_q)) begin
                    state_d = ST_ARMED;
                    cnt_d   = '0;
                end else if (cnt_q == SETTLE_C) begin
                    state_d      = ST_PRESENT;
                    cnt_d        = '0;
                    data_out_d   = shadow_q;
                    data_valid_d = 1'b1;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            ST_PRESENT: begin
                data_valid_d = 1'b1;
                if (ack) begin
                    state_d      = ST_RELEASE;
                    data_valid_d = 1'b0;
                    cnt_d        = '0;
                end
            end
            ST_RELEASE: begin
                if (cnt_q == SETTLE_C) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (strobe_s_q) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                end
            end
            default: begin
                state_d      = ST_IDLE;
                cnt_d        = '0;
                data_valid_d = 1'b0;
            end
        endcase

        waiting_d = (state_d == ST_ARMED) || (state_d == ST_SETTLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_meta_q     <= '0;
            in_s_q        <= '0;
            strobe_meta_q <= 1'b0;
            strobe_s_q    <= 1'b0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            shadow_q      <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            waiting_q     <= 1'b0;
        end else begin
            in_meta_q     <= in_meta_d;
            in_s_q        <= in_s_d;
            strobe_meta_q <= strobe_meta_d;
            strobe_s_q    <= strobe_s_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            waiting_q     <= waiting_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign waiting    = waiting_q;

`ifdef INPUT_OVERRUN_EN
    logic strobe_prev_q, strobe_prev_d;
    logic overrun_q, overrun_d;
    logic strobe_rise;

    // A press with nobody asking: IDLE, or RELEASE once the release is complete.
    always_comb begin
        strobe_prev_d = strobe_s_q;
        strobe_rise   = strobe_s_q & ~strobe_prev_q;
        overrun_d     = overrun_q;
        if ((state_q == ST_PRESENT) && ack) overrun_d = 1'b0;
        if (strobe_rise && ((state_q == ST_IDLE) ||
                            ((state_q == ST_RELEASE) && (cnt_q == SETTLE_C))))
            overrun_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe_prev_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            strobe_prev_q <= strobe_prev_d;
            overrun_q     <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_input_byte_controller.sv
// Directed bench for input_byte_controller at SETTLE_CYCLES=4 (pin-to-valid latency 7).
module tb_input_byte_controller;

    localparam int SETTLE = 4;
`ifdef INPUT_OVERRUN_EN
    localparam logic [31:0] OVR_EN = 32'd1;
`else
    localparam logic [31:0] OVR_EN = 32'd0;
`endif

    logic       clk = 1'b0;
    logic       reset, strobe, req, ack;
    logic [7:0] in_b;
    logic [7:0] data_out;
    logic       data_valid, waiting, overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    logic anydv;

    always #5 clk = ~clk;

    input_byte_controller #(.SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .reset(reset), .in(in_b), .strobe(strobe), .req(req),
        .data_out(data_out), .data_valid(data_valid), .ack(ack),
        .waiting(waiting), .overrun(overrun)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input int max, output int c);
        c = 0;
        while (!data_valid && c < max) begin
            step(1);
            c++;
        end
    endtask

    task automatic watch_dv(input int n, output logic seen);
        seen = 1'b0;
        repeat (n) begin
            step(1);
            if (data_valid) seen = 1'b1;
        end
    endtask

    initial begin
        reset = 1'b1; in_b = 8'h00; strobe = 1'b0; req = 1'b0; ack = 1'b0;
        step(3);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_data",  32'(data_out),   32'h00);
        chk("rst_wait",  32'(waiting),    32'd0);
        chk("rst_ovr",   32'(overrun),    32'd0);
        reset = 1'b0;
        step(1);

        // basic read
        req = 1'b1; step(1);
        chk("arm_wait", 32'(waiting), 32'd1);
        in_b = 8'h41; strobe = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            chk("basic_novalid", 32'(data_valid), 32'd0);
            chk("basic_wait",    32'(waiting),    32'd1);
        end
        step(1);
        chk("basic_valid", 32'(data_valid), 32'd1);
        chk("basic_data",  32'(data_out),   32'h41);
        chk("basic_wait0", 32'(waiting),    32'd0);
        step(2);
        chk("basic_hold", 32'(data_valid), 32'd1);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("basic_ack", 32'(data_valid), 32'd0);
        strobe = 1'b0; req = 1'b0; step(10);
        chk("basic_idle_wait", 32'(waiting), 32'd0);

        // bounce: high 2, low 1, high again
        req = 1'b1; step(1);
        in_b = 8'h5A; strobe = 1'b1; step(2);
        strobe = 1'b0; step(1);
        strobe = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            chk("bounce_novalid", 32'(data_valid), 32'd0);
        end
        step(1);
        chk("bounce_valid", 32'(data_valid), 32'd1);
        chk("bounce_data",  32'(data_out),   32'h5A);
        ack = 1'b1; step(1); ack = 1'b0;
        watch_dv(8, anydv);
        chk("bounce_single", 32'(anydv), 32'd0);
        strobe = 1'b0; req = 1'b0; step(10);

        // byte changes during settle
        req = 1'b1; step(1);
        in_b = 8'h10; strobe = 1'b1; step(3);
        in_b = 8'h11;
        wait_valid(15, cyc);
        chk("chg_found", 32'(data_valid), 32'd1);
        chk("chg_data",  32'(data_out),   32'h11);
        chk("chg_lat",   32'(cyc),        32'd8);

        // held button blocks re-capture
        ack = 1'b1; step(1); ack = 1'b0;
        chk("held_ack", 32'(data_valid), 32'd0);
        watch_dv(20, anydv);
        chk("held_block",  32'(anydv),   32'd0);
        chk("held_nowait", 32'(waiting), 32'd0);
        strobe = 1'b0; step(10);
        chk("held_rearm_wait", 32'(waiting),    32'd1);
        chk("held_rearm_dv",   32'(data_valid), 32'd0);
        strobe = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            chk("held_novalid", 32'(data_valid), 32'd0);
        end
        step(1);
        chk("held_valid", 32'(data_valid), 32'd1);
        chk("held_data",  32'(data_out),   32'h11);
        ack = 1'b1; step(1); ack = 1'b0;
        strobe = 1'b0; req = 1'b0; step(10);

        // withdraw during settle
        req = 1'b1; step(1);
        in_b = 8'h33; strobe = 1'b1; step(3);
        chk("wd_wait", 32'(waiting), 32'd1);
        req = 1'b0; step(1);
        chk("wd_idle", 32'(waiting), 32'd0);
        watch_dv(8, anydv);
        chk("wd_nodv", 32'(anydv),   32'd0);
        chk("wd_ovr",  32'(overrun), 32'd0);
        strobe = 1'b0; step(6);

        // reset while presenting
        req = 1'b1; step(1);
        in_b = 8'h77; strobe = 1'b1; step(7);
        chk("rp_valid", 32'(data_valid), 32'd1);
        chk("rp_data",  32'(data_out),   32'h77);
        reset = 1'b1; step(1);
        chk("rp_rst_dv",   32'(data_valid), 32'd0);
        chk("rp_rst_data", 32'(data_out),   32'h00);
        chk("rp_rst_wait", 32'(waiting),    32'd0);
        reset = 1'b0; strobe = 1'b0; req = 1'b0; step(6);

        // overrun: press with no request, then cleared by next ack
        strobe = 1'b1; step(4);
        chk("ovr_set", 32'(overrun), OVR_EN);
        strobe = 1'b0; step(6);
        req = 1'b1; step(1);
        in_b = 8'h22; strobe = 1'b1; step(7);
        chk("ovr_valid", 32'(data_valid), 32'd1);
        chk("ovr_data",  32'(data_out),   32'h22);
        chk("ovr_hold",  32'(overrun),    OVR_EN);
        ack = 1'b1; step(1); ack = 1'b0;
        chk("ovr_clr",   32'(overrun),    32'd0);
        chk("ovr_ackdv", 32'(data_valid), 32'd0);
        strobe = 1'b0; req = 1'b0; step(10);
        chk("end_ovr", 32'(overrun), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/input_byte_controller.md
Name: input_byte_controller

Overview:
Sequences the processor's ',' (read byte) instruction against the board's switch bank and "enter" push-button.
- Synchronizes the raw switch byte and button into the clk domain.
- Debounces the button and captures a stable byte only while the core is requesting input.
- Presents the captured byte to the core with a valid/ack handshake.
- Blocks double capture until the button is released.
- Sits between the top-level pins and the core's I/O unit.

Parameters:
SETTLE_CYCLES, 16, consecutive clk cycles the button (and byte) must be stable before capture or release is accepted; legal range 1..65535
CNT_W, $clog2(SETTLE_CYCLES+1), settle counter width; derived, not overridden

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
in  input  8  raw asynchronous switch byte
strobe  input  1  raw asynchronous enter button, active-high
req  input  1  core requests one byte; level, held until ack or withdrawn
data_out  output  8  captured byte
data_valid  output  1  data_out valid, held until ack
ack  input  1  core consumed data_out
waiting  output  1  high while the core is stalled waiting on the user (LED drive)
overrun  output  1  sticky flag, see Optional Feature

Behaviour:
- Reset (synchronous, active-high): state=IDLE, data_out=8'h00, data_valid=0, waiting=0, overrun=0, counter=0, synchronizer flops=0. Reset mid-operation aborts any state the next cycle; a byte being presented is dropped.
- Synchronization: in and strobe each pass through 2 flops (in_s, strobe_s). All logic below uses only in_s and strobe_s.
- IDLE: outputs idle. If req=1, go to ARMED.
- ARMED: waiting=1.
  - req=0 → IDLE.
  - strobe_s=1 → SETTLE; counter=1; latch in_s into a shadow register.
- SETTLE: waiting=1.
  - Each cycle with strobe_s=1 and in_s==shadow: counter+1.
  - strobe_s=0 or in_s!=shadow → ARMED, counter=0.
  - req=0 → IDLE; this has priority over the bounce checks.
  - counter reaches SETTLE_CYCLES → PRESENT; data_out=shadow; data_valid=1 on the next cycle.
- PRESENT: waiting=0, data_valid=1, data_out stable.
  - ack=1 → RELEASE; data_valid=0 the following cycle.
  - req=0 with no ack: still hold until ack; the byte is never silently dropped.
- RELEASE: counter counts consecutive cycles of strobe_s=0; any strobe_s=1 restarts it at 0. At SETTLE_CYCLES → IDLE, counter=0.
- ack while data_valid=0: ignored.
- Latency: strobe rising at the pin → data_valid=1 in 2 + SETTLE_CYCLES + 1 cycles, given stable input and req already high.
- Counter saturates at SETTLE_CYCLES and never wraps.
- Simultaneous req rising and strobe high in IDLE: enter ARMED first; capture starts the next cycle.
- Button held from a previous capture: RELEASE blocks re-capture until release is stable. A new req during RELEASE is accepted only after returning to IDLE.

Optional Feature:
INPUT_OVERRUN_EN
- Defined:
  - overrun sets to 1 when strobe_s rises while state is IDLE, or while state is RELEASE after a full release was seen (user pressed without a request).
  - Sticky; cleared by reset, or by the ack of the next accepted byte.
  - A simultaneous set and clear results in set.
- Undefined: overrun is tied to 0 and no detection logic is synthesized.
- Port list is identical in both builds.

Test Plan (SETTLE_CYCLES=4):
- Basic read: reset, req=1, in=8'h41, strobe high 10 cycles → data_valid=1 with data_out=8'h41 exactly 7 cycles after the strobe pin rises; waiting=1 until then. Ack one cycle → data_valid=0 next cycle.
- Bounce: strobe high 2 cycles, low 1, high 6 with in=8'h5A → exactly one capture of 8'h5A; counter restarts after the glitch.
- Byte change during settle: strobe held, in switches 8'h10→8'h11 at settle cycle 2 → capture 8'h11, never 8'h10.
- Held button: after ack, keep strobe high 20 cycles and reassert req → no second data_valid until strobe is low ≥4 cycles and then pressed again.
- Withdraw / reset: req dropped in SETTLE → IDLE, waiting=0, no data_valid. Reset asserted in PRESENT → data_valid=0 and data_out=8'h00 next cycle.
- Overrun (INPUT_OVERRUN_EN defined): press with req=0 → overrun=1; next completed read ack → overrun=0. Macro undefined → overrun stays 0 throughout.
